// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU opcodes,
// shifter types, forwarding selects and the NZCV flag layout.
package exe_stage_pkg;

    localparam int XLEN   = 32;   // datapath / PC width
    localparam int DEST_W = 4;    // register index width

    // ALU opcodes carried in EXE_CMD
    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    // Register shift types, Shift_operand[6:5]
    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_e;

    // Forwarding selects; code 11 behaves like 00
    typedef enum logic [1:0] {
        FWD_ID     = 2'b00,
        FWD_MEM    = 2'b01,
        FWD_WB     = 2'b10,
        FWD_ID_ALT = 2'b11
    } fwd_sel_e;

    // Status register layout, MSB first: N Z C V
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Execute-stage ALU: produces the result and the candidate NZCV value.
// Unknown opcodes yield 0 and leave the flags at their current value.
module exe_stage_alu
    import exe_stage_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [3:0]   cmd,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] val2,
    input  nzcv_t        flags,
    output logic [W-1:0] res,
    output nzcv_t        flags_next
);

    logic [W:0] sum;
    logic       c_new;
    logic       v_new;
    logic       known;

    // Opcode decode, arithmetic with carry/overflow, and flag assembly
    always_comb begin
        sum   = '0;
        res   = '0;
        c_new = flags.c;
        v_new = flags.v;
        known = 1'b1;
        unique case (exe_cmd_e'(cmd))
            EXE_MOV: res = val2;
            EXE_MVN: res = ~val2;
            EXE_ADD, EXE_ADC: begin
                sum = {1'b0, op1} + {1'b0, val2}
                    + ((exe_cmd_e'(cmd) == EXE_ADC) ? {{W{1'b0}}, flags.c} : '0);
                res   = sum[W-1:0];
                c_new = sum[W];
                v_new = (op1[W-1] == val2[W-1]) && (res[W-1] != op1[W-1]);
            end
            EXE_SUB, EXE_SBC: begin
                // a - b - borrow computed as a + ~b + carry_in; carry out is NOT borrow
                sum = {1'b0, op1} + {1'b0, ~val2}
                    + ((exe_cmd_e'(cmd) == EXE_SBC) ? {{W{1'b0}}, flags.c} : {{W{1'b0}}, 1'b1});
                res   = sum[W-1:0];
                c_new = sum[W];
                v_new = (op1[W-1] != val2[W-1]) && (res[W-1] != op1[W-1]);
            end
            EXE_AND: res = op1 & val2;
            EXE_ORR: res = op1 | val2;
            EXE_EOR: res = op1 ^ val2;
            default: begin
                res   = '0;
                known = 1'b0;
            end
        endcase

        if (known) begin
            flags_next.n = res[W-1];
            flags_next.z = (res == '0);
            flags_next.c = c_new;
            flags_next.v = v_new;
        end else begin
            flags_next = flags;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline: operand forwarding, Val2
// generation, ALU, NZCV register, branch target and the EX/MEM register.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int ADDRESS_LEN = XLEN,
    parameter int REG_ADDR_W  = DEST_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic [ADDRESS_LEN-1:0] pc,
    input  logic                   S,
    input  logic                   B,
    input  logic                   imm,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic                   WB_EN,
    input  logic [3:0]             EXE_CMD,
    input  logic [ADDRESS_LEN-1:0] Val_Rn,
    input  logic [ADDRESS_LEN-1:0] Val_Rm,
    input  logic [11:0]            Shift_operand,
    input  logic [23:0]            Signed_imm_24,
    input  logic [REG_ADDR_W-1:0]  Dest,
    input  logic [1:0]             sel_src1,
    input  logic [1:0]             sel_src2,
    input  logic [ADDRESS_LEN-1:0] mem_fwd_val,
    input  logic [ADDRESS_LEN-1:0] wb_fwd_val,
    output logic                   branch_taken,
    output logic [ADDRESS_LEN-1:0] branch_addr,
    output logic [3:0]             status,
    output logic [ADDRESS_LEN-1:0] alu_res_out,
    output logic [ADDRESS_LEN-1:0] st_val_out,
    output logic [REG_ADDR_W-1:0]  Dest_out,
    output logic                   WB_EN_out,
    output logic                   MEM_R_EN_out,
    output logic                   MEM_W_EN_out
);

    logic [1:0]             fwd_sel [2];
    logic [ADDRESS_LEN-1:0] fwd_id  [2];
    logic [ADDRESS_LEN-1:0] fwd_val [2];
    logic [ADDRESS_LEN-1:0] op1;
    logic [ADDRESS_LEN-1:0] op2r;
    logic [ADDRESS_LEN-1:0] val2;
    logic [ADDRESS_LEN-1:0] imm_word;
    logic [4:0]             shift_amt;
    logic [4:0]             rot_amt;
    logic [ADDRESS_LEN-1:0] alu_res;
    nzcv_t                  alu_flags;

    nzcv_t                  status_reg;
    logic [ADDRESS_LEN-1:0] alu_res_reg;
    logic [ADDRESS_LEN-1:0] st_val_reg;
    logic [REG_ADDR_W-1:0]  dest_reg;
    logic                   wb_en_reg;
    logic                   mem_r_en_reg;
    logic                   mem_w_en_reg;

    // Operand forwarding: index 0 feeds op1 (Rn), index 1 feeds op2r (Rm)
    assign fwd_sel[0] = sel_src1;
    assign fwd_sel[1] = sel_src2;
    assign fwd_id[0]  = Val_Rn;
    assign fwd_id[1]  = Val_Rm;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_val[gi] = (fwd_sel[gi] == FWD_MEM) ? mem_fwd_val :
                                 (fwd_sel[gi] == FWD_WB)  ? wb_fwd_val  :
                                                            fwd_id[gi];
        end
    endgenerate

    assign op1  = fwd_val[0];
    assign op2r = fwd_val[1];

    assign shift_amt = Shift_operand[11:7];
    assign rot_amt   = {Shift_operand[11:8], 1'b0};
    assign imm_word  = {{(ADDRESS_LEN-8){1'b0}}, Shift_operand[7:0]};

    // Val2: memory offset, rotated immediate, or shifted register operand
    always_comb begin
        val2 = op2r;
        if (MEM_R_EN || MEM_W_EN) begin
            val2 = {{(ADDRESS_LEN-12){1'b0}}, Shift_operand};
        end else if (imm) begin
            if (rot_amt != '0)
                val2 = (imm_word >> rot_amt) | (imm_word << (ADDRESS_LEN - int'(rot_amt)));
            else
                val2 = imm_word;
        end else if (shift_amt != '0) begin
            unique case (shift_e'(Shift_operand[6:5]))
                SHIFT_LSL: val2 = op2r << shift_amt;
                SHIFT_LSR: val2 = op2r >> shift_amt;
                SHIFT_ASR: val2 = $signed(op2r) >>> shift_amt;
                SHIFT_ROR: val2 = (op2r >> shift_amt) | (op2r << (ADDRESS_LEN - int'(shift_amt)));
                default:   val2 = op2r;
            endcase
        end
    end

    exe_stage_alu #(
        .W(ADDRESS_LEN)
    ) u_alu (
        .cmd        (EXE_CMD),
        .op1        (op1),
        .val2       (val2),
        .flags      (status_reg),
        .res        (alu_res),
        .flags_next (alu_flags)
    );

    // Branch resolution is purely combinational; word offset scaled to bytes
    assign branch_taken = B;
    assign branch_addr  = pc + {{(ADDRESS_LEN-26){Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

    // NZCV register: a frozen instruction is re-presented, so its update is dropped
    always_ff @(posedge clk) begin
        if (!rst)
            status_reg <= '0;
        else if (S && !freeze)
            status_reg <= alu_flags;
    end

    // EX/MEM boundary register, held while memory stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_res_reg  <= '0;
            st_val_reg   <= '0;
            dest_reg     <= '0;
            wb_en_reg    <= 1'b0;
            mem_r_en_reg <= 1'b0;
            mem_w_en_reg <= 1'b0;
        end else if (!freeze) begin
            alu_res_reg  <= alu_res;
            st_val_reg   <= op2r;
            dest_reg     <= Dest;
            wb_en_reg    <= WB_EN;
            mem_r_en_reg <= MEM_R_EN;
            mem_w_en_reg <= MEM_W_EN;
        end
    end

    assign status       = status_reg;
    assign alu_res_out  = alu_res_reg;
    assign st_val_out   = st_val_reg;
    assign Dest_out     = dest_reg;
    assign WB_EN_out    = wb_en_reg;
    assign MEM_R_EN_out = mem_r_en_reg;
    assign MEM_W_EN_out = mem_w_en_reg;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a driver issues one instruction per cycle
// and queues the expected post-edge state from an arithmetic reference model;
// a monitor pops one entry after each rising edge and compares.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze, S, B, imm, MEM_R_EN, MEM_W_EN, WB_EN;
    logic [31:0] pc, Val_Rn, Val_Rm, mem_fwd_val, wb_fwd_val;
    logic [3:0]  EXE_CMD, Dest;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [1:0]  sel_src1, sel_src2;
    logic        branch_taken, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
    logic [31:0] branch_addr, alu_res_out, st_val_out;
    logic [3:0]  status, Dest_out;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .pc(pc), .S(S), .B(B), .imm(imm),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .EXE_CMD(EXE_CMD),
        .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Shift_operand(Shift_operand),
        .Signed_imm_24(Signed_imm_24), .Dest(Dest), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .status(status), .alu_res_out(alu_res_out),
        .st_val_out(st_val_out), .Dest_out(Dest_out), .WB_EN_out(WB_EN_out),
        .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out)
    );

    typedef struct packed {
        logic        rst, freeze, s, b, imm, mr, mw, wb;
        logic [3:0]  cmd;
        logic [31:0] rn, rm, pc, memf, wbf;
        logic [11:0] so;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [1:0]  sel1, sel2;
    } stim_t;

    typedef struct packed {
        logic [31:0] res, st, baddr;
        logic [3:0]  dest, status;
        logic        wb, mr, mw, btaken;
    } exp_t;

    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -SMAX - 1;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          txn   = 0;
    logic [3:0]  m_status = '0;
    exp_t        m_regs   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (txn %0d): got %h expected %h", name, txn, act, exp);
        end
    endtask

    function automatic logic [31:0] rot_right(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] id,
                                         input logic [31:0] memv, input logic [31:0] wbv);
        if (sel == 2'd1) return memv;
        if (sel == 2'd2) return wbv;
        return id;
    endfunction

    function automatic logic [31:0] model_val2(input stim_t st, input logic [31:0] rmv);
        int amt;
        if (st.mr || st.mw) return {20'd0, st.so};
        if (st.imm) return rot_right({24'd0, st.so[7:0]}, 2 * int'(st.so[11:8]));
        amt = int'(st.so[11:7]);
        case (st.so[6:5])
            2'd0:    return rmv << amt;
            2'd1:    return rmv >> amt;
            2'd2:    return rmv[31] ? ~((~rmv) >> amt) : (rmv >> amt);
            default: return rot_right(rmv, amt);
        endcase
    endfunction

    // Reference ALU: 64-bit arithmetic, carry by magnitude, overflow by range
    task automatic alu_model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] cur, output logic [31:0] res, output logic [3:0] fl);
        longint unsigned ua, ub, u, borrow;
        longint          sa, sbv, s;
        logic            c, v;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        c = cur[1];
        v = cur[0];
        res = '0;
        case (cmd)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd2, 4'd3: begin
                u = ua + ub + ((cmd == 4'd3 && cur[1]) ? 64'd1 : 64'd0);
                s = sa + sbv + ((cmd == 4'd3 && cur[1]) ? 64'sd1 : 64'sd0);
                res = u[31:0];
                c = (u > 64'hFFFFFFFF);
                v = (s > SMAX) || (s < SMIN);
            end
            4'd4, 4'd5: begin
                borrow = (cmd == 4'd5 && !cur[1]) ? 64'd1 : 64'd0;
                u = ua - ub - borrow;
                s = sa - sbv - longint'(borrow);
                res = u[31:0];
                c = (ua >= ub + borrow);
                v = (s > SMAX) || (s < SMIN);
            end
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            default: res = '0;
        endcase
        if (cmd >= 4'd1 && cmd <= 4'd9)
            fl = {res[31], (res == 32'd0), c, v};
        else
            fl = cur;
    endtask

    task automatic issue(input stim_t st);
        exp_t        e;
        logic [31:0] op1, op2r, v2, r;
        logic [3:0]  fl;
        int          off;
        @(negedge clk);
        rst = st.rst; freeze = st.freeze; S = st.s; B = st.b; imm = st.imm;
        MEM_R_EN = st.mr; MEM_W_EN = st.mw; WB_EN = st.wb; EXE_CMD = st.cmd;
        Val_Rn = st.rn; Val_Rm = st.rm; pc = st.pc; mem_fwd_val = st.memf; wb_fwd_val = st.wbf;
        Shift_operand = st.so; Signed_imm_24 = st.imm24; Dest = st.dest;
        sel_src1 = st.sel1; sel_src2 = st.sel2;

        op1  = pick(st.sel1, st.rn, st.memf, st.wbf);
        op2r = pick(st.sel2, st.rm, st.memf, st.wbf);
        v2   = model_val2(st, op2r);
        alu_model(st.cmd, op1, v2, m_status, r, fl);
        if (!st.rst) begin
            m_status = '0;
            m_regs   = '0;
        end else if (!st.freeze) begin
            m_regs.res  = r;
            m_regs.st   = op2r;
            m_regs.dest = st.dest;
            m_regs.wb   = st.wb;
            m_regs.mr   = st.mr;
            m_regs.mw   = st.mw;
            if (st.s) m_status = fl;
        end
        e = m_regs;
        e.status = m_status;
        off = {{8{st.imm24[23]}}, st.imm24};
        e.baddr  = st.pc + 32'(off * 4);
        e.btaken = st.b;
        sb.push_back(e);
    endtask

    function automatic stim_t base();
        stim_t x;
        x = '0;
        x.rst = 1'b1;
        return x;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t x;
        int    kind;
        x = base();
        x.rst    = ($urandom_range(0, 49) != 0);
        x.freeze = ($urandom_range(0, 4) == 0);
        x.s      = 1'($urandom_range(0, 1));
        x.b      = ($urandom_range(0, 7) == 0);
        x.imm    = 1'($urandom_range(0, 1));
        kind     = int'($urandom_range(0, 5));
        x.mr     = (kind == 0);
        x.mw     = (kind == 1);
        x.wb     = (kind != 1) && ($urandom_range(0, 3) != 0);
        x.cmd    = 4'($urandom_range(0, 15));
        x.rn     = rand_word();
        x.rm     = rand_word();
        x.memf   = rand_word();
        x.wbf    = rand_word();
        x.pc     = $urandom;
        x.so     = 12'($urandom);
        x.imm24  = 24'($urandom);
        x.dest   = 4'($urandom);
        x.sel1   = 2'($urandom);
        x.sel2   = 2'($urandom);
        return x;
    endfunction

    // Monitor: one transaction becomes visible after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                txn++;
                chk("alu_res_out",  alu_res_out,         e.res);
                chk("st_val_out",   st_val_out,          e.st);
                chk("Dest_out",     32'(Dest_out),       32'(e.dest));
                chk("WB_EN_out",    32'(WB_EN_out),      32'(e.wb));
                chk("MEM_R_EN_out", 32'(MEM_R_EN_out),   32'(e.mr));
                chk("MEM_W_EN_out", 32'(MEM_W_EN_out),   32'(e.mw));
                chk("status",       32'(status),         32'(e.status));
                chk("branch_addr",  branch_addr,         e.baddr);
                chk("branch_taken", 32'(branch_taken),   32'(e.btaken));
                $display("txn %0d: res=%h st=%h dest=%0d wb/mr/mw=%b%b%b nzcv=%b b=%b baddr=%h",
                         txn, alu_res_out, st_val_out, Dest_out, WB_EN_out, MEM_R_EN_out,
                         MEM_W_EN_out, status, branch_taken, branch_addr);
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic
    initial begin
        stim_t s;
        rst = 1'b0; freeze = 1'b0; S = 1'b0; B = 1'b0; imm = 1'b0;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN = 1'b0; EXE_CMD = '0;
        Val_Rn = '0; Val_Rm = '0; pc = '0; mem_fwd_val = '0; wb_fwd_val = '0;
        Shift_operand = '0; Signed_imm_24 = '0; Dest = '0; sel_src1 = '0; sel_src2 = '0;

        s = base(); s.rst = 1'b0; s.freeze = 1'b1; s.s = 1'b1; s.cmd = 4'd2; s.rn = 32'h1234;
        issue(s);
        // ADD with flags: 0x7FFFFFFF + 1 -> N and V set
        s = base(); s.cmd = 4'd2; s.s = 1'b1; s.imm = 1'b1; s.rn = 32'h7FFF_FFFF;
        s.so = 12'h001; s.wb = 1'b1; s.dest = 4'd3;
        issue(s);
        // Reset must win over freeze and clear non-zero state
        s = base(); s.rst = 1'b0; s.freeze = 1'b1; s.s = 1'b1; s.cmd = 4'd2; s.imm = 1'b1;
        s.rn = 32'd5; s.so = 12'h001; s.wb = 1'b1;
        issue(s);
        s = base(); s.cmd = 4'd1; s.imm = 1'b1; s.so = 12'hF3F; s.wb = 1'b1; s.dest = 4'd1;
        issue(s);
        s = base(); s.cmd = 4'd1; s.rm = 32'h8000_0000; s.so = 12'h240; s.wb = 1'b1;
        issue(s);
        // Carry chain: SUB 5-5 sets C, SBC 10-3 = 7, SUB 3-5 clears C, SBC 10-3 = 6
        s = base(); s.cmd = 4'd4; s.s = 1'b1; s.rn = 32'd5; s.rm = 32'd5;
        issue(s);
        s = base(); s.cmd = 4'd5; s.rn = 32'd10; s.rm = 32'd3; s.wb = 1'b1;
        issue(s);
        s = base(); s.cmd = 4'd4; s.s = 1'b1; s.rn = 32'd3; s.rm = 32'd5;
        issue(s);
        s = base(); s.cmd = 4'd5; s.rn = 32'd10; s.rm = 32'd3; s.wb = 1'b1;
        issue(s);
        // Forwarding from both later stages
        s = base(); s.cmd = 4'd2; s.sel1 = 2'd1; s.sel2 = 2'd2; s.memf = 32'h10; s.wbf = 32'h20;
        s.rn = 32'hDEAD; s.rm = 32'hBEEF; s.wb = 1'b1; s.dest = 4'd7;
        issue(s);
        s = base(); s.cmd = 4'd2; s.mw = 1'b1; s.sel2 = 2'd2; s.wbf = 32'h20; s.rn = 32'h1000;
        s.rm = 32'h5555; s.so = 12'h004;
        issue(s);
        s = base(); s.cmd = 4'd2; s.mr = 1'b1; s.wb = 1'b1; s.rn = 32'h2000; s.so = 12'hFFC;
        s.dest = 4'd9; s.sel1 = 2'd3;
        issue(s);
        // Branch target, then two frozen cycles with flag update and branch asserted
        s = base(); s.pc = 32'h100; s.imm24 = 24'hFFFFFE; s.b = 1'b1;
        issue(s);
        for (int i = 0; i < 2; i++) begin
            s = base(); s.freeze = 1'b1; s.s = 1'b1; s.b = 1'b1; s.cmd = 4'd4; s.rn = 32'd1;
            s.rm = 32'd2; s.wb = 1'b1; s.dest = 4'd12; s.pc = 32'h4000; s.imm24 = 24'h000010;
            issue(s);
        end
        // Flush bubble: zero controls
        s = base(); s.rn = 32'hCAFE; s.rm = 32'hF00D; s.cmd = 4'd0;
        issue(s);

        for (int i = 0; i < 400; i++) issue(rand_stim());

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
